fifo_umbral: RTL and testbench
==============================

Name: fifo_umbral

Overview:
- Synchronous FIFO with programmable almost-full/almost-empty thresholds.
- Instantiated as the main FIFO, the VC0/VC1 FIFOs and the D0/D1 FIFOs of the routing path.
- Its empty flag feeds pop_Main/valid generation and the vc0/vc1 empty logic.
- Its almost_full flag is the pause signal fed back to the upstream stage (pause_vc0, pause_vc1, pause_d0, pause_d1).

Parameters:
DATA_WIDTH, 6, width of each word; bit DATA_WIDTH-1 is the routing/selector bit, stored untouched.
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH = 8 entries.

Ports:
clk  input  1  single clock, all state on rising edge
reset_L  input  1  asynchronous, active-low reset
data_in  input  DATA_WIDTH  write word
push  input  1  write request
pop  input  1  read request
umbral_alto  input  ADDR_WIDTH+1  almost-full threshold, 1..DEPTH, held stable outside reset
umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold, 0..DEPTH-1, held stable outside reset
data_out  output  DATA_WIDTH  registered read word
valid_out  output  1  data_out carries a freshly popped word this cycle
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= umbral_alto; used as pause upstream
almost_empty  output  1  count <= umbral_bajo
error  output  1  sticky overflow/underflow indicator
count  output  ADDR_WIDTH+1  current occupancy

Behaviour:
- Reset (reset_L=0, asynchronous, also mid-operation):
  - wr_ptr, rd_ptr, count, data_out, valid_out, error all 0; empty=1, full=0, almost_full=0, almost_empty=1.
  - In-flight words are discarded. Memory contents are don't-care; they are never read while empty.
- Write accepted: push && (!full || pop_accepted).
  - mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (wraps 7->0).
- Read accepted: pop && !empty.
  - data_out <= mem[rd_ptr]; valid_out <= 1 on the same edge, so data is visible 1 cycle after pop is sampled.
  - rd_ptr increments modulo DEPTH.
  - No accepted read: valid_out <= 0 and data_out holds its previous value.
- Count:
  - +1 on write only, -1 on read only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Flags: pure decode of the count register, so they change on the same edge as count with no extra latency.
- Simultaneous push+pop:
  - Non-empty, non-full: both proceed, count unchanged.
  - Full: both proceed (read frees the slot in the same cycle), full stays 1, no error.
  - Empty: no bypass. Pop is rejected (underflow, error=1), the push is written, count becomes 1, valid_out=0.
- Overflow: push while full with no accepted pop. Word dropped, pointers and count unchanged, error <= 1.
- Underflow: pop while empty. Ignored, valid_out=0, data_out holds, error <= 1.
- error is sticky; only reset_L clears it.
- Thresholds:
  - umbral_alto=DEPTH makes almost_full equal to full.
  - umbral_bajo=0 makes almost_empty equal to empty.
  - Out-of-range thresholds are a configuration error; behaviour is simply the compare result.
- No internal state machine beyond pointers, count and error. Throughput is one write and one read per cycle.

Test Plan:
1. Reset then idle, umbral_alto=6, umbral_bajo=1.
   - Required: empty=1, almost_empty=1, full=0, almost_full=0, count=0, valid_out=0, data_out=0, error=0.
2. Push 0x21,0x02,0x23,...,0x08 (8 words) on consecutive cycles.
   - count reaches 2 -> almost_empty=0.
   - count reaches 6 -> almost_full=1.
   - count reaches 8 -> full=1.
   - A 9th push of 0x3F is dropped: count=8, error=1.
3. From full, pop 8 times on consecutive cycles.
   - data_out is 0x21,0x02,...,0x08 in order, each valid_out=1 one cycle after its pop.
   - empty=1 after the 8th pop; a 9th pop leaves valid_out=0 and data_out=0x08.
4. Wrap-around: from reset, push 5 and pop 5 words, then push 6 more (wr_ptr wraps 7->0), then pop all.
   - Required: FIFO order preserved, count returns to 0, error=0.
5. Full with push+pop in the same cycle (data_in=0x15).
   - Oldest word appears on data_out, count stays 8, full=1, error=0.
   - 0x15 is read out last.
6. Reset mid-stream: assert reset_L=0 between clock edges with count=4.
   - Outputs clear immediately, without waiting for clk.
   - After release, the first pop is an underflow and the next pushed word is the first word read.

Source files
------------

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds.
// Registered read port; the flags are registered from the next-state occupancy, so they move on the same edge as count.
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  error_q, error_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  almost_full_q, almost_full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  wr_ok_s, rd_ok_s;

    // Next-state logic: a pop on a full FIFO frees the slot the simultaneous push uses; no bypass when empty.
    always_comb begin
        rd_ok_s    = pop && (count_q != '0);
        wr_ok_s    = push && ((count_q != DEPTH_C) || rd_ok_s);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        valid_out_d = rd_ok_s;
        error_d    = error_q || (push && !wr_ok_s) || (pop && !rd_ok_s);
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE_C;
            data_out_d = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d   = rd_ptr_q;
            data_out_d = data_out_q;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        empty_d        = (count_d == '0);
        full_d         = (count_d == DEPTH_C);
        almost_full_d  = (count_d >= umbral_alto);
        almost_empty_d = (count_d <= umbral_bajo);
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            data_out_q     <= '0;
            valid_out_q    <= 1'b0;
            error_q        <= 1'b0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            data_out_q     <= data_out_d;
            valid_out_q    <= valid_out_d;
            error_q        <= error_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    // Storage array; never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign error        = error_q;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed plus randomized bench for fifo_umbral, checked against a queue-based occupancy model.
module tb_fifo_umbral;

    localparam int DW    = 6;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [DW-1:0] data_in;
    logic          push;
    logic          pop;
    logic [AW:0]   umbral_alto;
    logic [AW:0]   umbral_bajo;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic          error;
    logic [AW:0]   count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    logic          m_err;
    logic [DW-1:0] m_data;
    logic          m_valid;

    always #5 clk = ~clk;

    fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .push(push), .pop(pop),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty), .error(error), .count(count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        int n;
        n = mq.size();
        check({step, ":count"},        32'(count),        32'(n));
        check({step, ":empty"},        32'(empty),        32'(n == 0));
        check({step, ":full"},         32'(full),         32'(n == DEPTH));
        check({step, ":almost_full"},  32'(almost_full),  32'(32'(n) >= 32'(umbral_alto)));
        check({step, ":almost_empty"}, 32'(almost_empty), 32'(32'(n) <= 32'(umbral_bajo)));
        check({step, ":valid_out"},    32'(valid_out),    32'(m_valid));
        check({step, ":data_out"},     32'(data_out),     32'(m_data));
        check({step, ":error"},        32'(error),        32'(m_err));
    endtask

    task automatic model_reset();
        mq.delete();
        m_err   = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, check just after it.
    task automatic cycle(input string step, input logic p, input logic r, input logic [DW-1:0] d);
        logic rd;
        logic wr;
        @(negedge clk);
        push    = p;
        pop     = r;
        data_in = d;
        @(posedge clk);
        rd = r && (mq.size() != 0);
        wr = p && ((mq.size() != DEPTH) || rd);
        if (rd) begin
            m_data  = mq.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wr) mq.push_back(d);
        if ((p && !wr) || (r && !rd)) m_err = 1'b1;
        #1;
        check_all(step);
    endtask

    task automatic apply_reset(input logic [AW:0] ua, input logic [AW:0] ub);
        @(negedge clk);
        reset_L     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        umbral_alto = ua;
        umbral_bajo = ub;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        data_in     = '0;
        umbral_alto = 4'd6;
        umbral_bajo = 4'd1;
        model_reset();

        // 1: reset then idle
        apply_reset(4'd6, 4'd1);
        cycle("t1_idle", 1'b0, 1'b0, 6'h00);

        // 2: fill with 0x21,0x02,0x23,...,0x08, then overflow with 0x3F
        for (int i = 0; i < 8; i++) begin
            cycle("t2_push", 1'b1, 1'b0, DW'(i + 1) | ((i % 2 == 0) ? 6'h20 : 6'h00));
        end
        check("t2_full_const", 32'(full), 32'd1);
        cycle("t2_overflow", 1'b1, 1'b0, 6'h3F);
        check("t2_err_const", 32'(error), 32'd1);

        // 3: drain in order, then underflow
        for (int i = 0; i < 8; i++) begin
            cycle("t3_pop", 1'b0, 1'b1, 6'h00);
        end
        cycle("t3_underflow", 1'b0, 1'b1, 6'h00);
        check("t3_hold_const", 32'(data_out), 32'h08);

        // 4: wrap-around from reset
        apply_reset(4'd6, 4'd1);
        for (int i = 0; i < 5; i++) cycle("t4_push_a", 1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 5; i++) cycle("t4_pop_a", 1'b0, 1'b1, 6'h00);
        for (int i = 0; i < 6; i++) cycle("t4_push_b", 1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 6; i++) cycle("t4_pop_b", 1'b0, 1'b1, 6'h00);
        check("t4_err_const", 32'(error), 32'd0);

        // 5: push+pop while full
        for (int i = 0; i < 8; i++) cycle("t5_fill", 1'b1, 1'b0, DW'($urandom));
        cycle("t5_pushpop", 1'b1, 1'b1, 6'h15);
        for (int i = 0; i < 8; i++) cycle("t5_drain", 1'b0, 1'b1, 6'h00);
        check("t5_last_const", 32'(data_out), 32'h15);

        // 6: asynchronous reset between edges with four words stored
        for (int i = 0; i < 4; i++) cycle("t6_fill", 1'b1, 1'b0, DW'($urandom));
        #2;
        reset_L = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        cycle("t6_underflow", 1'b0, 1'b1, 6'h00);
        cycle("t6_push", 1'b1, 1'b0, 6'h2A);
        cycle("t6_pop", 1'b0, 1'b1, 6'h00);
        check("t6_first_const", 32'(data_out), 32'h2A);

        // Randomized traffic with random thresholds, biased toward filling or draining per batch
        for (int b = 0; b < 4; b++) begin
            int push_pct;
            int pop_pct;
            push_pct = (b % 2 == 0) ? 70 : 40;
            pop_pct  = (b % 2 == 0) ? 40 : 70;
            apply_reset((AW + 1)'($urandom_range(1, DEPTH)), (AW + 1)'($urandom_range(0, DEPTH - 1)));
            for (int i = 0; i < 150; i++) begin
                cycle("rand",
                      ($urandom_range(0, 99) < push_pct) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < pop_pct) ? 1'b1 : 1'b0,
                      DW'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
